// File: rtl/sail_mem_pkg.sv
// Shared types for the memory write-commit path: buffered request record,
// commit FSM states and address/byte widths.
package sail_mem_pkg;

  localparam int SAIL_MEM_ADDR_W    = 64;
  localparam int SAIL_MEM_BYTE_W    = 8;
  localparam int SAIL_MEM_MAX_BYTES = 8;
  localparam int SAIL_MEM_NB_W      = 4;

  typedef struct packed {
    logic [SAIL_MEM_ADDR_W-1:0]                    addr;
    logic [SAIL_MEM_NB_W-1:0]                      nbytes;
    logic [SAIL_MEM_BYTE_W*SAIL_MEM_MAX_BYTES-1:0] data;
    logic                                          tag_en;
    logic                                          tag;
  } sail_mem_req;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTES = 2'd1,
    TAG   = 2'd2
  } sail_mem_state_e;

  // A request that would write zero bytes or more than the store path carries.
  function automatic logic sail_mem_req_bad(input logic [SAIL_MEM_NB_W-1:0] n,
                                            input int max_bytes);
    return (n == '0) || (int'(n) > max_bytes);
  endfunction

endpackage

// File: rtl/sail_mem_req_fifo.sv
// Synchronous FIFO of write requests: valid/ready push side, pop strobe,
// head always visible, occupancy exported as level.
module sail_mem_req_fifo
  import sail_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_valid,
  output logic        push_ready,
  input  sail_mem_req push_req,
  input  logic        pop,
  output sail_mem_req head,
  output logic        empty,
  output logic [AW:0] level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  sail_mem_req   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_fire, pop_fire;

  assign push_ready = (count_q != FULL_LVL);
  assign empty      = (count_q == '0);
  assign level      = count_q;
  assign head       = mem_q[rd_ptr_q];
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_req;
  end

endmodule

// File: rtl/sail_mem_commit.sv
// Drains buffered multi-byte write requests into the byte/tag store,
// one little-endian byte per handshake, optionally followed by a tag write.
module sail_mem_commit
  import sail_mem_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_BYTES = 8,
  parameter int NB_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_addr,
  input  logic [NB_W-1:0]          in_nbytes,
  input  logic [8*MAX_BYTES-1:0]   in_data,
  input  logic                     in_tag_en,
  input  logic                     in_tag,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [63:0]              mem_paddr,
  output logic [7:0]               mem_data,
  output logic                     tag_valid,
  output logic [63:0]              tag_paddr,
  output logic                     tag_data,
  output logic                     busy,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Once raised, mem_valid/tag_valid and their payloads hold until mem_ready.

  sail_mem_req     in_req, fifo_head;
  logic            fifo_empty, fifo_pop;
  sail_mem_state_e state_q, state_d;
  sail_mem_req     req_q, req_d;
  logic [NB_W-1:0] idx_q, idx_d, idx_next;
  logic [63:0]     byte_shift;
  logic            err_q, err_d;
  logic            mem_valid_q, mem_valid_d;
  logic [63:0]     mem_paddr_q, mem_paddr_d;
  logic [7:0]      mem_data_q, mem_data_d;
  logic            tag_valid_q, tag_valid_d;
  logic [63:0]     tag_paddr_q, tag_paddr_d;
  logic            tag_data_q, tag_data_d;

  always_comb begin
    in_req        = '0;
    in_req.addr   = in_addr;
    in_req.nbytes = in_nbytes;
    in_req.data   = in_data;
    in_req.tag_en = in_tag_en;
    in_req.tag    = in_tag;
  end

  sail_mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_req   (in_req),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .level      (level)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    idx_d       = idx_q;
    err_d       = 1'b0;
    fifo_pop    = 1'b0;
    mem_valid_d = mem_valid_q;
    mem_paddr_d = mem_paddr_q;
    mem_data_d  = mem_data_q;
    tag_valid_d = tag_valid_q;
    tag_paddr_d = tag_paddr_q;
    tag_data_d  = tag_data_q;
    idx_next    = idx_q + NB_W'(1);
    byte_shift  = req_q.data >> {idx_next, 3'b000};
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          // Malformed requests are consumed and reported, never written.
          if (sail_mem_req_bad(fifo_head.nbytes, MAX_BYTES)) begin
            err_d = 1'b1;
          end else begin
            state_d     = BYTES;
            req_d       = fifo_head;
            idx_d       = '0;
            mem_valid_d = 1'b1;
            mem_paddr_d = fifo_head.addr;
            mem_data_d  = fifo_head.data[7:0];
          end
        end
      end
      BYTES: begin
        if (mem_ready) begin
          if (idx_q == req_q.nbytes - NB_W'(1)) begin
            mem_valid_d = 1'b0;
            if (req_q.tag_en) begin
              state_d     = TAG;
              tag_valid_d = 1'b1;
              tag_paddr_d = req_q.addr;
              tag_data_d  = req_q.tag;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d       = idx_next;
            mem_paddr_d = req_q.addr + 64'(idx_next);
            mem_data_d  = byte_shift[7:0];
          end
        end
      end
      TAG: begin
        if (mem_ready) begin
          tag_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_paddr_q <= '0;
      mem_data_q  <= '0;
      tag_valid_q <= 1'b0;
      tag_paddr_q <= '0;
      tag_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      mem_valid_q <= mem_valid_d;
      mem_paddr_q <= mem_paddr_d;
      mem_data_q  <= mem_data_d;
      tag_valid_q <= tag_valid_d;
      tag_paddr_q <= tag_paddr_d;
      tag_data_q  <= tag_data_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_paddr = mem_paddr_q;
  assign mem_data  = mem_data_q;
  assign tag_valid = tag_valid_q;
  assign tag_paddr = tag_paddr_q;
  assign tag_data  = tag_data_q;
  assign err       = err_q;
  assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_sail_mem_commit.sv
// Bench for sail_mem_commit: requests expand into expected byte/tag/err
// events at push time; a negedge monitor pops and compares as the DUT commits.
module tb_sail_mem_commit;

  localparam int DEPTH     = 4;
  localparam int MAX_BYTES = 8;
  localparam int NB_W      = 4;
  localparam int EV_W      = 75;
  localparam logic [1:0] K_BYTE = 2'd0;
  localparam logic [1:0] K_TAG  = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [63:0]            in_addr;
  logic [NB_W-1:0]        in_nbytes;
  logic [8*MAX_BYTES-1:0] in_data;
  logic                   in_tag_en;
  logic                   in_tag;
  logic                   mem_valid;
  logic                   mem_ready;
  logic [63:0]            mem_paddr;
  logic [7:0]             mem_data;
  logic                   tag_valid;
  logic [63:0]            tag_paddr;
  logic                   tag_data;
  logic                   busy;
  logic                   err;
  logic [2:0]             level;

  // event = {first_byte_of_request, kind, addr, data}
  logic [EV_W-1:0] exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_pushed = 0;
  int   n_started = 0;
  int   err_seen = 0;
  logic head_started = 1'b0;
  logic rand_done;
  logic prev_mstall, prev_tstall;
  logic [63:0] prev_paddr, prev_tpaddr;
  logic [7:0]  prev_mdata;
  logic        prev_tdata;

  sail_mem_commit #(.DEPTH(DEPTH), .MAX_BYTES(MAX_BYTES), .NB_W(NB_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_nbytes (in_nbytes),
    .in_data   (in_data),
    .in_tag_en (in_tag_en),
    .in_tag    (in_tag),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_paddr (mem_paddr),
    .mem_data  (mem_data),
    .tag_valid (tag_valid),
    .tag_paddr (tag_paddr),
    .tag_data  (tag_data),
    .busy      (busy),
    .err       (err),
    .level     (level)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: a request becomes its little-endian byte stream,
  // an optional tag write, or a single error event if malformed.
  task automatic model_push(input logic [63:0] a, input logic [NB_W-1:0] n,
                            input logic [63:0] d, input logic te, input logic t);
    logic [7:0] b;
    if (n == 0 || int'(n) > MAX_BYTES) begin
      exp_q.push_back({1'b1, K_ERR, 64'd0, 8'd0});
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        b = d[8*i +: 8];
        exp_q.push_back({(i == 0), K_BYTE, a + 64'(i), b});
      end
      if (te) exp_q.push_back({1'b0, K_TAG, a, {7'd0, t}});
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after acceptance.
  task automatic push_req(input logic [63:0] a, input logic [NB_W-1:0] n,
                          input logic [63:0] d, input logic te, input logic t);
    int   waited;
    logic acc;
    waited = 0;
    acc = 1'b0;
    in_valid = 1'b1; in_addr = a; in_nbytes = n; in_data = d;
    in_tag_en = te; in_tag = t;
    while (!acc && waited < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      waited++;
    end
    checks++;
    if (acc) begin
      model_push(a, n, d, te, t);
      n_pushed++;
    end else begin
      failures++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required acceptance", waited);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc, input string name);
    int c;
    c = 0;
    while (c < max_cyc && (exp_q.size() != 0 || busy)) begin
      @(posedge clk); #2;
      c++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      failures++;
      $display("FAIL %s: %0d events still pending, busy=%0b, required 0 and 0", name, exp_q.size(), busy);
    end
  endtask

  task automatic check_event(input logic [1:0] kind, input logic [63:0] a, input logic [7:0] d);
    logic [EV_W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h, required no event", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      head_started = 1'b0;
      if (e[73:72] !== kind || e[71:8] !== a || e[7:0] !== d) begin
        failures++;
        $display("FAIL commit_event: got kind %0d addr %h data %h, required kind %0d addr %h data %h",
                 kind, a, d, e[73:72], e[71:8], e[7:0]);
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mstall = 1'b0;
      prev_tstall = 1'b0;
    end else begin
      chk("mutex", {63'd0, mem_valid && tag_valid}, 64'd0);
      if (prev_mstall) begin
        chk("stall_mem_valid", {63'd0, mem_valid}, 64'd1);
        chk("stall_mem_paddr", mem_paddr, prev_paddr);
        chk("stall_mem_data", {56'd0, mem_data}, {56'd0, prev_mdata});
      end
      if (prev_tstall) begin
        chk("stall_tag_valid", {63'd0, tag_valid}, 64'd1);
        chk("stall_tag_paddr", tag_paddr, prev_tpaddr);
        chk("stall_tag_data", {63'd0, tag_data}, {63'd0, prev_tdata});
      end
      prev_mstall = mem_valid && !mem_ready;
      prev_tstall = tag_valid && !mem_ready;
      prev_paddr  = mem_paddr;
      prev_mdata  = mem_data;
      prev_tpaddr = tag_paddr;
      prev_tdata  = tag_data;
      // The first byte of a request appearing means it has left the FIFO.
      if (mem_valid && exp_q.size() != 0 && !head_started && exp_q[0][74]) begin
        head_started = 1'b1;
        n_started++;
      end
      if (mem_valid && mem_ready) check_event(K_BYTE, mem_paddr, mem_data);
      if (tag_valid && mem_ready) check_event(K_TAG, tag_paddr, {7'd0, tag_data});
      if (err) begin
        err_seen++;
        n_started++;
        check_event(K_ERR, 64'd0, 8'd0);
      end
      chk("level_model", {61'd0, level}, 64'(n_pushed - n_started));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    logic [63:0]     ra, rd;
    logic [NB_W-1:0] rn;
    int              r;
    rst_n = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_nbytes = '0; in_data = '0;
    in_tag_en = 1'b0; in_tag = 1'b0; mem_ready = 1'b0; rand_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_tag_valid", {63'd0, tag_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_level", {61'd0, level}, 64'd0);
    chk("rst_mem_paddr", mem_paddr, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic 4-byte write with latency check
    @(posedge clk); #1 mem_ready = 1'b1;
    push_req(64'h1000, 4'd4, 64'hDEADBEEF, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency_cycle1_mem_valid", {63'd0, mem_valid}, 64'd0);
    @(negedge clk);
    chk("latency_cycle2_mem_valid", {63'd0, mem_valid}, 64'd1);
    drain(50, "drain_basic");
    chk("basic_busy_low", {63'd0, busy}, 64'd0);

    // Single byte plus tag
    @(posedge clk); #1;
    push_req(64'h2000, 4'd1, 64'h5A, 1'b1, 1'b1);
    drain(50, "drain_tag");

    // Backpressure: fill FIFO while the store stalls
    @(posedge clk); #1 mem_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_req(64'h4000 + 64'(16*i), 4'(i + 2), {$urandom, $urandom}, 1'(i & 1), 1'(i >> 1));
    @(negedge clk);
    chk("full_level", {61'd0, level}, 64'd4);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    fork
      push_req(64'h5000, 4'd3, 64'h00C0FFEE, 1'b1, 1'b0);
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("held_level", {61'd0, level}, 64'd4);
        chk("held_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1 mem_ready = 1'b1;
      end
    join
    drain(200, "drain_backpressure");

    // Malformed requests and address wrap
    e0 = err_seen;
    @(posedge clk); #1;
    push_req(64'h6000, 4'd0, 64'h11, 1'b1, 1'b1);
    push_req(64'h6100, 4'd9, 64'h22, 1'b0, 1'b0);
    push_req(64'hFFFF_FFFF_FFFF_FFFE, 4'd4, 64'h44332211, 1'b0, 1'b0);
    drain(100, "drain_malformed_wrap");
    chk("err_pulses", 64'(err_seen - e0), 64'd2);

    // Reset in the middle of an 8-byte request with two more queued
    @(posedge clk); #1;
    push_req(64'h3000, 4'd8, 64'h8877665544332211, 1'b1, 1'b1);
    push_req(64'h3100, 4'd4, 64'hAABBCCDD, 1'b0, 1'b0);
    push_req(64'h3200, 4'd2, 64'h1234, 1'b1, 1'b0);
    r = 0;
    while (!(mem_valid && mem_paddr == 64'h3002) && r < 50) begin
      @(posedge clk); #1;
      r++;
    end
    chk("reached_byte3", {63'd0, mem_valid && mem_paddr == 64'h3002}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("midrst_tag_valid", {63'd0, tag_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_level", {61'd0, level}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_mem_paddr", mem_paddr, 64'd0);
    exp_q.delete();
    n_pushed = 0; n_started = 0; head_started = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("postrst_busy", {63'd0, busy}, 64'd0);

    // Random traffic with random store backpressure
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          ra = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                           : {$urandom, $urandom};
          rd = {$urandom, $urandom};
          r = $urandom_range(0, 19);
          if (r == 0)      rn = 4'd0;
          else if (r == 1) rn = 4'($urandom_range(9, 15));
          else             rn = 4'($urandom_range(1, 8));
          push_req(ra, rn, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1 mem_ready = 1'($urandom_range(0, 1));
        end
        #1 mem_ready = 1'b1;
      end
    join
    drain(2000, "drain_random");
    chk("final_level", {61'd0, level}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
